inst_fetch_queue: RTL and testbench

Parametrised decoupling FIFO between the fetch and decode stages. It is the successor to the fixed two-slot fetch-to-decode handshake, generalised to IN_WIDTH enqueue slots, OUT_WIDTH dequeue slots and DEPTH entries. It adds compaction of sparse input slots, partial consumption by decode, and single-cycle flush. Each entry carries an opaque payload, for example {pc, inst, prediction bits}.

---
 rtl/inst_fetch_queue.sv | 129 ++++++++++++
 tb/tb_inst_fetch_queue.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//
// Decoupling FIFO between fetch and decode. Fetch presents up to IN_WIDTH
// slots per cycle with an arbitrary valid pattern. Valid slots are compacted,
// in ascending slot order, into a circular buffer. Decode sees the oldest
// OUT_WIDTH entries and consumes any number of them from the head each cycle.
// A flush empties the queue in a single cycle.
//
// Handshake semantics:
//   fetch -> queue : a group {in_valid, in_data} is taken when in_allowin is
//                    high, flush is low and at least one in_valid bit is set.
//                    When in_allowin is low fetch holds its group; nothing is
//                    written. in_allowin depends only on the registered count.
//   queue -> decode: out_valid[j] marks entry head+j as present; decode takes
//                    the first out_accept entries, which must not exceed the
//                    number of valid slots. Larger requests are clamped.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   flush        discard all contents (next cycle empty)
//   in_valid     per-slot valid from fetch
//   in_data      slot i payload at [i*DATA_W +: DATA_W]
//   in_allowin   a full IN_WIDTH group fits this cycle
//   out_valid    slot j holds a valid entry
//   out_data     slot j payload = entry at head+j
//   out_accept   number of head entries consumed this cycle
//   count        current occupancy
//   empty        count == 0
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
   parameter int IN_WIDTH  = 2,
   parameter int OUT_WIDTH = 2,
   parameter int DEPTH     = 16,
   parameter int DATA_W    = 64
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           flush,
   input  logic [IN_WIDTH-1:0]            in_valid,
   input  logic [IN_WIDTH*DATA_W-1:0]     in_data,
   output logic                           in_allowin,
   output logic [OUT_WIDTH-1:0]           out_valid,
   output logic [OUT_WIDTH*DATA_W-1:0]    out_data,
   input  logic [$clog2(OUT_WIDTH+1)-1:0] out_accept,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     head;
   logic [PW-1:0]     tail;

   logic [CW-1:0]     free_slots;
   logic [CW-1:0]     enq_k;
   logic [CW-1:0]     enq_n;
   logic [CW-1:0]     deq_avail;
   logic [CW-1:0]     accept_ext;
   logic [CW-1:0]     deq_a;
   logic [PW-1:0]     slot_off [IN_WIDTH];
   logic              enq_fire;

   // Credit toward fetch comes from the registered count only, so there is
   // no combinational path from out_accept to in_allowin.
   assign free_slots = CW'(DEPTH) - count;
   assign in_allowin = (free_slots >= CW'(IN_WIDTH));
   assign empty      = (count == '0);
   assign enq_fire   = in_allowin && (|in_valid) && !flush;
   assign enq_n      = enq_fire ? enq_k : '0;

   // Compaction: each valid slot's write offset is the number of valid
   // slots below it; enq_k ends up as the total popcount.
   always_comb begin
      enq_k = '0;
      for (int i = 0; i < IN_WIDTH; i++) begin
         slot_off[i] = PW'(enq_k);
         enq_k       = enq_k + CW'(in_valid[i]);
      end
   end

   // Decode may take at most min(count, OUT_WIDTH); anything above is clamped.
   always_comb begin
      deq_avail  = (count < CW'(OUT_WIDTH)) ? count : CW'(OUT_WIDTH);
      accept_ext = CW'(out_accept);
      deq_a      = (accept_ext < deq_avail) ? accept_ext : deq_avail;
   end

   // Head-relative combinational read; pointer sum wraps mod DEPTH.
   always_comb begin
      out_valid = '0;
      out_data  = '0;
      for (int j = 0; j < OUT_WIDTH; j++) begin
         out_valid[j]                  = (CW'(j) < count);
         out_data[j*DATA_W +: DATA_W]  = mem[head + PW'(j)];
      end
   end

   // Storage: only valid slots are written, at tail + compacted offset.
   always_ff @(posedge clk) begin
      if (enq_fire) begin
         for (int i = 0; i < IN_WIDTH; i++) begin
            if (in_valid[i]) begin
               mem[tail + slot_off[i]] <= in_data[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   // Pointers and occupancy. Reset and flush both empty the queue and drop
   // any enqueue/dequeue presented in the same cycle.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PW'(deq_a);
         tail  <= tail + PW'(enq_n);
         count <= count + enq_n - deq_a;
      end
   end

   accept_legal: assert property (@(posedge clk) disable iff (reset)
                                  accept_ext <= deq_avail);

endmodule

// File: tb/tb_inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_queue
//
// Scoreboard bench for inst_fetch_queue. The reference model is an ordered
// queue of expected entries (exp_q): accepted fetch groups push their valid
// slots in order, decode consumption pops from the front, flush/reset clear
// it. A negedge monitor compares the DUT's outputs against the model.
// -----------------------------------------------------------------------------
module tb_inst_fetch_queue;

  localparam int IN_WIDTH  = 2;
  localparam int OUT_WIDTH = 2;
  localparam int DEPTH     = 16;
  localparam int DATA_W    = 64;
  localparam int CW        = $clog2(DEPTH+1);
  localparam int AW        = $clog2(OUT_WIDTH+1);

  // ---------------- clock / reset / DUT ----------------
  logic                        clk = 1'b0;
  logic                        reset = 1'b1;
  logic                        flush = 1'b0;
  logic [IN_WIDTH-1:0]         in_valid = '0;
  logic [IN_WIDTH*DATA_W-1:0]  in_data = '0;
  logic                        in_allowin;
  logic [OUT_WIDTH-1:0]        out_valid;
  logic [OUT_WIDTH*DATA_W-1:0] out_data;
  logic [AW-1:0]               out_accept = '0;
  logic [CW-1:0]               count;
  logic                        empty;

  always #5 clk = ~clk;

  inst_fetch_queue #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .DEPTH    (DEPTH),
    .DATA_W   (DATA_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_allowin(in_allowin),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_accept(out_accept),
    .count     (count),
    .empty     (empty)
  );

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit started = 1'b0;
  int mon_n;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: mid-cycle, compare against the model, then retire what decode
  // consumes this cycle (nothing is retired in a flush cycle).
  always @(negedge clk) begin
    if (started && !reset) begin
      mon_n = exp_q.size();
      check("count", 64'(count), 64'(mon_n));
      check("empty", 64'(empty), 64'(mon_n == 0));
      check("in_allowin", 64'(in_allowin), 64'((DEPTH - mon_n) >= IN_WIDTH));
      for (int j = 0; j < OUT_WIDTH; j++) begin
        check("out_valid", 64'(out_valid[j]), 64'(j < mon_n));
        if (j < mon_n) check("out_data", out_data[j*DATA_W +: DATA_W], exp_q[j]);
      end
      if (!flush) begin
        for (int j = 0; j < int'(out_accept); j++) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [DATA_W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    in_valid = '0;
    out_accept = '0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    started = 1'b1;
  endtask

  // One cycle of stimulus; the model update is pushed as the group is issued.
  task automatic step(input logic [IN_WIDTH-1:0] v, input logic [DATA_W-1:0] d0,
                      input logic [DATA_W-1:0] d1, input int a, input logic f);
    bit allow;
    in_valid   = v;
    in_data    = {d1, d0};
    out_accept = AW'(a);
    flush      = f;
    allow      = (DEPTH - exp_q.size()) >= IN_WIDTH;
    @(posedge clk);
    #1;
    if (f) exp_q.delete();
    else if (allow) begin
      if (v[0]) exp_q.push_back(d0);
      if (v[1]) exp_q.push_back(d1);
    end
    in_valid   = '0;
    out_accept = '0;
    flush      = 1'b0;
  endtask

  function automatic int max_accept();
    return (exp_q.size() < OUT_WIDTH) ? exp_q.size() : OUT_WIDTH;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int r;
    do_reset();

    // Full pair, then idle so it stays visible.
    step(2'b11, 64'hA, 64'hB, 0, 1'b0);
    step(2'b00, 64'h0, 64'h0, 0, 1'b0);

    // Sparse slot1-only into an empty queue.
    do_reset();
    step(2'b10, 64'hDEAD, 64'hC, 0, 1'b0);
    step(2'b00, 64'h0, 64'h0, 1, 1'b0);

    // Fill to 16, then hold a group against a full queue.
    do_reset();
    for (int i = 0; i < DEPTH / 2; i++) step(2'b11, rnd64(), rnd64(), 0, 1'b0);
    for (int i = 0; i < 3; i++) step(2'b11, 64'hBAD0, 64'hBAD1, 0, 1'b0);
    while (exp_q.size() > 0) step(2'b00, 64'h0, 64'h0, max_accept(), 1'b0);

    // Wrap: walk head/tail to 15, then D lands at 15 and E at 0.
    do_reset();
    for (int i = 0; i < DEPTH - 1; i++)
      step(2'b01, rnd64(), 64'h0, (exp_q.size() > 0) ? 1 : 0, 1'b0);
    step(2'b00, 64'h0, 64'h0, 1, 1'b0);
    step(2'b11, 64'hD, 64'hE, 0, 1'b0);
    step(2'b00, 64'h0, 64'h0, 1, 1'b0);
    step(2'b00, 64'h0, 64'h0, 1, 1'b0);
    step(2'b00, 64'h0, 64'h0, 0, 1'b0);

    // Flush at count 5 with concurrent enqueue and accept, then refill.
    do_reset();
    step(2'b11, rnd64(), rnd64(), 0, 1'b0);
    step(2'b11, rnd64(), rnd64(), 0, 1'b0);
    step(2'b01, rnd64(), 64'h0, 0, 1'b0);
    step(2'b11, 64'hF0, 64'hF1, 2, 1'b1);
    step(2'b11, 64'h51, 64'h52, 0, 1'b0);
    step(2'b00, 64'h0, 64'h0, 2, 1'b0);

    // Randomised traffic with occasional flush and mid-stream reset.
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 99);
      if (r < 2) do_reset();
      else step(IN_WIDTH'($urandom_range(0, 3)), rnd64(), rnd64(),
                $urandom_range(0, max_accept()), r < 6);
    end
    while (exp_q.size() > 0) step(2'b00, 64'h0, 64'h0, max_accept(), 1'b0);
    step(2'b00, 64'h0, 64'h0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
